// File: rtl/multicycle_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle adder.
// State encoding plus chunk-count and index-width functions used at elaboration.
package multicycle_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk build still needs a 1-bit index register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/multicycle_adder_if.sv
// Operand/result handshake bundle for the multi-cycle adder.
// The sub signal exists only when MULTICYCLE_ADDER_SUB_EN is defined.
interface multicycle_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
`ifdef MULTICYCLE_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   S;
    logic             ovf;

`ifdef MULTICYCLE_ADDER_SUB_EN
    modport master (
        output in_valid, A, B, Cin, sub, out_ready,
        input  in_ready, out_valid, S, ovf
    );
    modport slave (
        input  in_valid, A, B, Cin, sub, out_ready,
        output in_ready, out_valid, S, ovf
    );
`else
    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, S, ovf
    );
    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, S, ovf
    );
`endif

endinterface

// File: rtl/multicycle_adder_chunk.sv
// Purpose: combinational CHUNK-bit adder slice, (x,y,cin) -> {cout,sum} plus carry into the MSB.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the owning FSM decides when the result is consumed.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             cin_msb
);

    logic [CHUNK:0] full;

    always_comb begin
        full    = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
        sum     = full[CHUNK-1:0];
        cout    = full[CHUNK];
        // sum_msb = x_msb ^ y_msb ^ carry_in_msb, so the carry into the MSB falls out directly.
        cin_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ full[CHUNK-1];
    end

endmodule

// File: rtl/multicycle_adder.sv
// Purpose: WIDTH-bit add (or subtract with MULTICYCLE_ADDER_SUB_EN) of A+B+Cin, CHUNK bits per clock.
// Latency: out_valid rises NCHUNK cycles after the accept edge; result held in DONE.
// Backpressure: in_ready only in IDLE; DONE holds S/ovf until out_ready, then returns to IDLE.
module multicycle_adder
    import multicycle_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic              Clock,
    input  logic              Resetn,
    multicycle_adder_if.slave bus
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    if ((WIDTH % CHUNK) != 0) begin : g_width_chk
        $error("multicycle_adder: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    state_t           state_q;
    state_t           state_d;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH:0]   s_q;
    logic             ovf_q;

    logic             accept;
    logic             last_chunk;
    logic             sub_mode;
    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] y_chunk;
    logic [CHUNK-1:0] sum_chunk;
    logic             cout_chunk;
    logic             cin_msb_chunk;

`ifdef MULTICYCLE_ADDER_SUB_EN
    assign sub_mode = bus.sub;
`else
    assign sub_mode = 1'b0;
`endif

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.S         = s_q;
    assign bus.ovf       = ovf_q;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_chunk = (idx_q == LAST);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (last_chunk)    state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_comb begin
        x_chunk = a_q[idx_q*CHUNK +: CHUNK];
        y_chunk = b_q[idx_q*CHUNK +: CHUNK];
    end

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .x       (x_chunk),
        .y       (y_chunk),
        .cin     (carry_q),
        .sum     (sum_chunk),
        .cout    (cout_chunk),
        .cin_msb (cin_msb_chunk)
    );

    // Operands are snapshotted at accept; subtraction folds into an add of ~B with carry-in 1.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            s_q     <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= sub_mode ? ~bus.B : bus.B;
            carry_q <= sub_mode ? 1'b1 : bus.Cin;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            s_q[idx_q*CHUNK +: CHUNK] <= sum_chunk;
            carry_q                   <= cout_chunk;
            if (last_chunk) begin
                idx_q     <= '0;
                s_q[WIDTH] <= cout_chunk;
                ovf_q     <= cin_msb_chunk ^ cout_chunk;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed-vector bench for multicycle_adder at WIDTH=16, CHUNK=4.
// Expected sums, carries and overflow flags are worked out by hand per vector.
module tb_multicycle_adder;
    import multicycle_adder_pkg::*;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    multicycle_adder_if #(.WIDTH(WIDTH)) bus ();

    multicycle_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .Clock  (clk),
        .Resetn (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sub(input logic s);
`ifdef MULTICYCLE_ADDER_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub request ignored in add-only build");
`endif
    endtask

    // Runs one transaction; hold is the number of cycles out_ready stays low in DONE.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic s, input logic [16:0] exp_s,
                         input logic exp_ovf, input int hold);
        int n;
        logic [16:0] s_seen;
        logic        ovf_seen;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = cin;
        drive_sub(s);
        bus.in_valid = 1'b1;
        tick();
        // Scramble inputs after accept to prove they were captured.
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = a ^ b;
        bus.Cin      = ~cin;
        drive_sub(1'b0);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(NCH));
        if (bus.out_valid !== 1'b1) return;
        check({tag, "_S"}, 32'(bus.S), 32'(exp_s));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
        s_seen   = bus.S;
        ovf_seen = bus.ovf;
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold_vld"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_rdy"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_S"}, 32'(bus.S), 32'(exp_s));
            check({tag, "_hold_ovf"}, 32'({bus.ovf, ovf_seen}), 32'({exp_ovf, exp_ovf}));
        end
        check({tag, "_pre_hs_rdy"}, 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_post_vld"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(bus.in_ready), 32'd1);
        check({tag, "_post_S"}, 32'(bus.S), 32'(s_seen));
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.Cin       = 1'b0;
        bus.out_ready = 1'b0;
        drive_sub(1'b0);
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_S", 32'(bus.S), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("basic",   16'h1234, 16'h0FFF, 1'b0, 1'b0, 17'h02233, 1'b0, 0);
        do_op("ripple",  16'hFFFF, 16'h0001, 1'b1, 1'b0, 17'h10001, 1'b0, 0);
        do_op("posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1, 3);
        do_op("negovf",  16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1, 0);
        do_op("cinonly", 16'h0000, 16'h0000, 1'b1, 1'b0, 17'h00001, 1'b0, 1);

        // Abort in the middle of RUN: reset must clear outputs without a clock edge.
        bus.A        = 16'hABCD;
        bus.B        = 16'h1111;
        bus.Cin      = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_S", 32'(bus.S), 32'd0);
        check("abort_ovf", 32'(bus.ovf), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        #3;
        rst_n = 1'b1;
        tick();
        do_op("after_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 17'h01000, 1'b0, 0);

`ifdef MULTICYCLE_ADDER_SUB_EN
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0, 0);
        do_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 17'h17FFF, 1'b1, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
